prog_counter: RTL and testbench
===============================

PROG_COUNTER -- requirements
Module: prog_counter

Interface
REQ-001 Parameter WIDTH, default 8, counter and data width in bits (>=2).
REQ-002 Parameter STEP_W, default 4, step input width in bits (<= WIDTH).
REQ-003 Parameter RESET_VAL, default all ones of WIDTH, count value after reset.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 load  input  1  synchronous load of data_in.
REQ-007 data_in  input  WIDTH  load value.
REQ-008 counter_on  input  1  count enable.
REQ-009 count_up  input  1  direction: 1 up, 0 down.
REQ-010 step  input  STEP_W  unsigned increment per enabled cycle.
REQ-011 limit_lo  input  WIDTH  lower bound, unsigned, inclusive.
REQ-012 limit_hi  input  WIDTH  upper bound, unsigned, inclusive.
REQ-013 saturate  input  1  mode: 1 saturate at bound, 0 wrap to opposite bound.
REQ-014 clear_flags  input  1  synchronous clear of sat_flag.
REQ-015 count  output  WIDTH  registered counter value.
REQ-016 at_hi / at_lo  output  1 each  combinational: count == limit_hi / count == limit_lo.
REQ-017 wrap_pulse  output  1  registered, one cycle high per wrap event.
REQ-018 sat_flag  output  1  registered, sticky, saturation occurred.
REQ-019 load_clamped  output  1  registered, one cycle high when a load was clamped.
REQ-020 cfg_err  output  1  combinational: limit_lo > limit_hi.

Function
REQ-021 Priority per edge: reset > load > counter_on > hold.
REQ-022 Load, cfg_err=0: count <= data_in clamped to [limit_lo, limit_hi]; load_clamped=1 next cycle iff clamping changed the value.
REQ-023 Load, cfg_err=1: count <= data_in unclamped; load_clamped=0.
REQ-024 counter_on=1 with cfg_err=1 or step=0: count holds, no pulses, no flags.
REQ-025 Up: sum = count + step computed in WIDTH+1 bits, no truncation; sum <= limit_hi -> count <= sum.
REQ-026 Up overflow (sum > limit_hi): wrap mode -> count <= limit_lo, wrap_pulse=1; saturate mode -> count <= limit_hi, sat_flag set.
REQ-027 Down: no-underflow test is count >= limit_lo and (count - limit_lo) >= step; then count <= count - step.
REQ-028 Down underflow (test fails): wrap mode -> count <= limit_hi, wrap_pulse=1; saturate mode -> count <= limit_lo, sat_flag set.
REQ-029 Reaching a bound exactly (sum == limit_hi or difference == limit_lo) is not overflow: no pulse, no flag.
REQ-030 Count outside bounds after limit change: next enabled count step is evaluated per REQ-025..028, forcing it back into range.
REQ-031 wrap_pulse and load_clamped are high exactly one cycle, coincident with the new count value.
REQ-032 sat_flag stays set until clear_flags; set event and clear_flags in the same cycle -> sat_flag=1.
REQ-033 saturate, count_up, step, limits are sampled each edge; changes take effect on the next edge with no pipeline delay.

Reset
REQ-034 reset=1 forces immediately, independent of clk: count=RESET_VAL, wrap_pulse=0, sat_flag=0, load_clamped=0.
REQ-035 Reset mid-count or coincident with load: reset wins; first operation on first rising edge after deassertion.
REQ-036 Initial simulation value equals reset value.

Verification
REQ-037 WIDTH=8, lo=10, hi=20, wrap, step=3, up from load 15 -> 18, 10 (wrap_pulse), 13.
REQ-038 Same limits, saturate, down step=4 from 12 -> 10, sat_flag=1; clear_flags -> sat_flag=0; simultaneous underflow + clear_flags -> sat_flag=1.
REQ-039 Load data_in=250 with lo=10, hi=20 -> count=20, load_clamped=1 for one cycle; load 15 -> load_clamped=0.
REQ-040 lo=30, hi=20 -> cfg_err=1, counter_on holds count, load 25 -> count=25.
REQ-041 lo=0, hi=255, up step=15 from 250 wrap mode -> count=0, wrap_pulse=1 (no 8-bit truncation artifact).
REQ-042 reset asserted mid-count between clock edges -> count=255 immediately, all flags 0; load+reset same edge -> 255.

Source files
------------

// File: rtl/prog_counter.sv
// Bounded up/down counter with programmable step, wrap or saturate at the limits, and clamped loads.
// Single cycle: count and event pulses update on the edge after the command; there is no backpressure.
module prog_counter #(
  parameter int unsigned       WIDTH     = 8,
  parameter int unsigned       STEP_W    = 4,
  parameter logic [WIDTH-1:0]  RESET_VAL = {WIDTH{1'b1}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [WIDTH-1:0]  data_in_i,
  input  logic              counter_on_i,
  input  logic              count_up_i,
  input  logic [STEP_W-1:0] step_i,
  input  logic [WIDTH-1:0]  limit_lo_i,
  input  logic [WIDTH-1:0]  limit_hi_i,
  input  logic              saturate_i,
  input  logic              clear_flags_i,
  output logic [WIDTH-1:0]  count_o,
  output logic              at_hi_o,
  output logic              at_lo_o,
  output logic              wrap_pulse_o,
  output logic              sat_flag_o,
  output logic              load_clamped_o,
  output logic              cfg_err_o
);

  logic [WIDTH-1:0] count_q = RESET_VAL;
  logic [WIDTH-1:0] count_d;
  logic             wrap_q = 1'b0;
  logic             wrap_d;
  logic             sat_q = 1'b0;
  logic             sat_d;
  logic             clamp_q = 1'b0;
  logic             clamp_d;
  logic             sat_set;

  logic             cfg_err;
  logic [WIDTH:0]   step_x;
  logic [WIDTH:0]   sum_w;
  logic [WIDTH-1:0] diff_lo;
  logic             up_ok;
  logic             dn_ok;

  assign cfg_err = limit_lo_i > limit_hi_i;
  assign step_x  = {{(WIDTH+1-STEP_W){1'b0}}, step_i};
  // One extra bit keeps the overflow test exact even when limit_hi is the maximum code.
  assign sum_w   = {1'b0, count_q} + step_x;
  assign up_ok   = sum_w <= {1'b0, limit_hi_i};
  assign diff_lo = count_q - limit_lo_i;
  assign dn_ok   = (count_q >= limit_lo_i) && ({1'b0, diff_lo} >= step_x);

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    clamp_d = 1'b0;
    sat_set = 1'b0;
    if (load_i) begin
      if (cfg_err) begin
        count_d = data_in_i;
      end else if (data_in_i < limit_lo_i) begin
        count_d = limit_lo_i;
        clamp_d = 1'b1;
      end else if (data_in_i > limit_hi_i) begin
        count_d = limit_hi_i;
        clamp_d = 1'b1;
      end else begin
        count_d = data_in_i;
      end
    end else if (counter_on_i && !cfg_err && (step_i != '0)) begin
      if (count_up_i) begin
        if (up_ok) begin
          count_d = sum_w[WIDTH-1:0];
        end else if (saturate_i) begin
          count_d = limit_hi_i;
          sat_set = 1'b1;
        end else begin
          count_d = limit_lo_i;
          wrap_d  = 1'b1;
        end
      end else begin
        // An out-of-range count below limit_lo fails dn_ok and is pulled back into range.
        if (dn_ok) begin
          count_d = count_q - step_x[WIDTH-1:0];
        end else if (saturate_i) begin
          count_d = limit_lo_i;
          sat_set = 1'b1;
        end else begin
          count_d = limit_hi_i;
          wrap_d  = 1'b1;
        end
      end
    end
    sat_d = sat_set | (sat_q & ~clear_flags_i);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= RESET_VAL;
      wrap_q  <= 1'b0;
      sat_q   <= 1'b0;
      clamp_q <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      sat_q   <= sat_d;
      clamp_q <= clamp_d;
    end
  end

  assign count_o        = count_q;
  assign at_hi_o        = count_q == limit_hi_i;
  assign at_lo_o        = count_q == limit_lo_i;
  assign wrap_pulse_o   = wrap_q;
  assign sat_flag_o     = sat_q;
  assign load_clamped_o = clamp_q;
  assign cfg_err_o      = cfg_err;

endmodule

// File: tb/tb_prog_counter.sv
// Scoreboard bench for prog_counter: directed vectors push expected post-edge state, a monitor compares.
module tb_prog_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic [7:0] data_in;
  logic       counter_on;
  logic       count_up;
  logic [3:0] step;
  logic [7:0] limit_lo;
  logic [7:0] limit_hi;
  logic       saturate;
  logic       clear_flags;
  logic [7:0] count;
  logic       at_hi, at_lo, wrap_pulse, sat_flag, load_clamped, cfg_err;

  prog_counter dut (
    .clk            (clk),
    .reset          (reset),
    .load_i         (load),
    .data_in_i      (data_in),
    .counter_on_i   (counter_on),
    .count_up_i     (count_up),
    .step_i         (step),
    .limit_lo_i     (limit_lo),
    .limit_hi_i     (limit_hi),
    .saturate_i     (saturate),
    .clear_flags_i  (clear_flags),
    .count_o        (count),
    .at_hi_o        (at_hi),
    .at_lo_o        (at_lo),
    .wrap_pulse_o   (wrap_pulse),
    .sat_flag_o     (sat_flag),
    .load_clamped_o (load_clamped),
    .cfg_err_o      (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [13:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic logic [13:0] observe();
    return {count, wrap_pulse, sat_flag, load_clamped, at_hi, at_lo, cfg_err};
  endfunction

  task automatic check(input string tag, input logic [13:0] act, input logic [13:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got cnt=%0d wrap=%b sat=%b clamp=%b hi=%b lo=%b cerr=%b, want cnt=%0d wrap=%b sat=%b clamp=%b hi=%b lo=%b cerr=%b",
                  tag, act[13:6], act[5], act[4], act[3], act[2], act[1], act[0],
                  want[13:6], want[5], want[4], want[3], want[2], want[1], want[0]);
  endtask

  // Monitor: every expected entry describes the state just after the next rising edge.
  always @(posedge clk) begin : mon
    exp_t e;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(e.tag, observe(), e.v);
    end
  end

  task automatic cyc(input string tag, input logic ld, input logic [7:0] din, input logic on,
                     input logic up, input logic [3:0] stp, input logic sat, input logic clr,
                     input logic [7:0] lo, input logic [7:0] hi,
                     input logic [7:0] ec, input logic ew, input logic es, input logic ecl);
    exp_t e;
    @(negedge clk);
    load = ld; data_in = din; counter_on = on; count_up = up; step = stp;
    saturate = sat; clear_flags = clr; limit_lo = lo; limit_hi = hi;
    e.tag = tag;
    e.v   = {ec, ew, es, ecl, ec == hi, ec == lo, lo > hi};
    exp_q.push_back(e);
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; data_in = 8'd0; counter_on = 1'b0; count_up = 1'b1;
    step = 4'd0; limit_lo = 8'd10; limit_hi = 8'd20; saturate = 1'b0; clear_flags = 1'b0;
    #2;
    check("reset_state", observe(), {8'd255, 3'b000, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    reset = 1'b0;

    //   tag              ld din on up stp sat clr lo  hi   cnt w s cl
    cyc("ld_clamp_hi",    1, 250, 0, 1, 0, 0, 0, 10, 20,  20, 0, 0, 1);
    cyc("ld_clamp_lo",    1,   3, 0, 1, 0, 0, 0, 10, 20,  10, 0, 0, 1);
    cyc("ld_in_range",    1,  15, 0, 1, 0, 0, 0, 10, 20,  15, 0, 0, 0);
    cyc("up3_a",          0,   0, 1, 1, 3, 0, 0, 10, 20,  18, 0, 0, 0);
    cyc("up3_wrap",       0,   0, 1, 1, 3, 0, 0, 10, 20,  10, 1, 0, 0);
    cyc("up3_b",          0,   0, 1, 1, 3, 0, 0, 10, 20,  13, 0, 0, 0);
    cyc("hold",           0,   0, 0, 1, 3, 0, 0, 10, 20,  13, 0, 0, 0);
    cyc("up7_exact_hi",   0,   0, 1, 1, 7, 0, 0, 10, 20,  20, 0, 0, 0);
    cyc("ld12",           1,  12, 0, 0, 4, 1, 0, 10, 20,  12, 0, 0, 0);
    cyc("dn4_sat",        0,   0, 1, 0, 4, 1, 0, 10, 20,  10, 0, 1, 0);
    cyc("clr",            0,   0, 0, 0, 4, 1, 1, 10, 20,  10, 0, 0, 0);
    cyc("dn4_sat_clr",    0,   0, 1, 0, 4, 1, 1, 10, 20,  10, 0, 1, 0);
    cyc("step0_hold",     0,   0, 1, 0, 0, 1, 0, 10, 20,  10, 0, 1, 0);
    cyc("clr2",           0,   0, 0, 0, 0, 1, 1, 10, 20,  10, 0, 0, 0);
    cyc("dn2_wrap",       0,   0, 1, 0, 2, 0, 0, 10, 20,  20, 1, 0, 0);
    cyc("dn2",            0,   0, 1, 0, 2, 0, 0, 10, 20,  18, 0, 0, 0);
    cyc("ld14",           1,  14, 0, 0, 4, 0, 0, 10, 20,  14, 0, 0, 0);
    cyc("dn4_exact_lo",   0,   0, 1, 0, 4, 0, 0, 10, 20,  10, 0, 0, 0);
    cyc("up15_sat",       0,   0, 1, 1, 15, 1, 0, 10, 20, 20, 0, 1, 0);
    cyc("clr3",           0,   0, 0, 1, 15, 1, 1, 10, 20, 20, 0, 0, 0);
    cyc("cfg_hold_up",    0,   0, 1, 1, 3, 0, 0, 30, 20,  20, 0, 0, 0);
    cyc("cfg_ld25",       1,  25, 0, 1, 3, 0, 0, 30, 20,  25, 0, 0, 0);
    cyc("cfg_hold_dn",    0,   0, 1, 0, 3, 1, 0, 30, 20,  25, 0, 0, 0);
    cyc("oob_up_wrap",    0,   0, 1, 1, 1, 0, 0,  0, 15,   0, 1, 0, 0);
    cyc("ld250",          1, 250, 0, 1, 15, 0, 0, 0, 255, 250, 0, 0, 0);
    cyc("up15_wrap_full", 0,   0, 1, 1, 15, 0, 0, 0, 255,   0, 1, 0, 0);
    cyc("ld250b",         1, 250, 0, 1, 15, 1, 0, 0, 255, 250, 0, 0, 0);
    cyc("up15_sat_full",  0,   0, 1, 1, 15, 1, 0, 0, 255, 255, 0, 1, 0);
    cyc("ld5",            1,   5, 0, 1, 1, 0, 0,  0, 255,   5, 0, 1, 0);
    cyc("up1",            0,   0, 1, 1, 1, 0, 0,  0, 255,   6, 0, 1, 0);

    // Asynchronous reset between edges, while still counting.
    @(negedge clk);
    #1 reset = 1'b1;
    #1 check("async_reset", observe(), {8'd255, 3'b000, 1'b1, 1'b0, 1'b0});
    cyc("rst_over_load",  1,   5, 1, 1, 1, 0, 0,  0, 255, 255, 0, 0, 0);
    cyc("post_rst_ld",    1,   5, 1, 1, 1, 0, 0,  0, 255,   5, 0, 0, 0);
    reset = 1'b0;
    cyc("post_rst_up",    0,   0, 1, 1, 1, 0, 0,  0, 255,   6, 0, 0, 0);

    @(negedge clk);
    load = 1'b0; counter_on = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    n_chk++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
